// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver (data width, parity, stop bits)
//
// Receives LSB-first serial frames on rxd and presents each completed word
// in a valid/ready holding register together with its parity and framing
// error flags. A frame that completes while the holding register is still
// occupied (and not being read that cycle) is dropped and reported on
// overrun. A line held low is reported once as a framing-error word of
// zeros, and nothing more is received until the line goes high again.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit (>= 8)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 none, 1 odd, 2 even
//   STOP_BITS     1 or 2
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   rxd         asynchronous serial input, idles high
//   rx_data     received word, stable while rx_valid is high
//   rx_valid    holding register occupied
//   rx_ready    consumer accepts the held word
//   parity_err  parity mismatch for the held word (qualified by rx_valid)
//   frame_err   a stop bit was sampled low (qualified by rx_valid)
//   overrun     one-cycle pulse when a completed frame is discarded
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each bit decision is the 2-of-3
//                        majority of the synchronised input over the last
//                        three cycles ending at the sample point.

module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF   = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]  D_LAST = 4'(DATA_BITS - 1);
    localparam logic        S_LAST = 1'(STOP_BITS - 1);
    localparam logic        ODD    = (PARITY == 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic                 stp, stp_n;
    logic                 s1, rxs;
    logic [DATA_BITS-1:0] sh;
    logic                 par_flag, frm_flag;
    logic                 bitv;
    logic                 shift_en, par_set, frm_set, commit;
    logic                 load;

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is rxs one cycle ago, hist[1] two cycles ago
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rxs};
    end

    assign bitv = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
    assign bitv = rxs;
`endif

    // A completed frame may load when the register is empty or being read now
    assign load = commit & (~rx_valid | rx_ready);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 16'd1;
        idx_n    = idx;
        stp_n    = stp;
        shift_en = 1'b0;
        par_set  = 1'b0;
        frm_set  = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                stp_n = 1'b0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    // high at the start midpoint: treat as a glitch
                    state_n = bitv ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == C_LAST) begin
                    cnt_n    = '0;
                    shift_en = 1'b1;
                    idx_n    = idx + 4'd1;
                    if (idx == D_LAST) state_n = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (cnt == C_LAST) begin
                    cnt_n   = '0;
                    par_set = bitv != ((^sh) ^ ODD);
                    state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == C_LAST) begin
                    cnt_n   = '0;
                    frm_set = ~bitv;
                    if (stp == S_LAST) begin
                        commit  = 1'b1;
                        // leave at mid-stop-bit so back-to-back frames work;
                        // a low stop bit means the line may be in break
                        state_n = bitv ? IDLE : BRK;
                    end else begin
                        stp_n = 1'b1;
                    end
                end
            end
            BRK: begin
                cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            stp        <= 1'b0;
            sh         <= '0;
            par_flag   <= 1'b0;
            frm_flag   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            s1    <= rxd;
            rxs   <= s1;
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            stp   <= stp_n;

            // LSB arrives first, so after DATA_BITS shifts it sits in sh[0]
            if (shift_en) sh <= {bitv, sh[DATA_BITS-1:1]};

            if (state == IDLE) begin
                par_flag <= 1'b0;
                frm_flag <= 1'b0;
            end else begin
                if (par_set) par_flag <= 1'b1;
                if (frm_set) frm_flag <= 1'b1;
            end

            overrun <= commit & ~load;
            if (load) begin
                rx_data    <= sh;
                parity_err <= par_flag;
                frame_err  <= frm_flag | frm_set;
                rx_valid   <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver. It supersedes the fixed 8N1 receiver with configurable data width, parity and stop bits, plus per-word parity/framing error flags, break handling, a valid/ready output holding register and overrun reporting. It sits between the board `rxd` pin and the command/sample-control logic, in the single system clock domain.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit (C). Legal values: C ≥ 8.
- `DATA_BITS`, 8: data bits per frame. Legal values: 5..9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits. Legal values: 1 or 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  DATA_BITS  received word, LSB first on the wire; stable while `rx_valid` is high.
- `rx_valid`  out  1  word available in the holding register.
- `rx_ready`  in  1  consumer accepts the word.
- `parity_err`  out  1  parity mismatch for the held word; qualified by `rx_valid`; 0 when PARITY=0.
- `frame_err`  out  1  at least one stop bit was sampled 0 for the held word; qualified by `rx_valid`.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped.

## Operation
- Input path: `rxd` passes through a 2-flop synchroniser (both flops reset to 1). All decisions use the synchronised value `rxs`.
- Counters:
  - Bit counter is 16 bits wide.
  - Half-period H = (C-1)/2, integer division.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
- IDLE:
  - Counters are cleared.
  - `rxs`=0 → START.
- START:
  - Count 0..H.
  - At H: `rxs`=0 → DATA with the counter cleared; `rxs`=1 → IDLE (glitch rejected, no output).
- DATA:
  - Sample at counter = C-1, then clear the counter.
  - Shift into `rx_data[idx]`, idx 0..DATA_BITS-1.
  - After the last bit → PAR if PARITY≠0, else STOP.
- PAR:
  - One sample after C cycles.
  - Expected value: odd mode gives XOR(data)^1; even mode gives XOR(data).
  - Mismatch sets the internal parity flag.
- STOP:
  - STOP_BITS samples, C cycles apart.
  - Any sample equal to 0 sets the internal frame flag.
  - After the final stop sample, the frame is complete (see the commit rule below).
  - Next state is IDLE if the final stop sample was 1, otherwise BRK.
  - The FSM returns to IDLE at mid-stop-bit, so back-to-back frames are received.
- BRK: wait until `rxs`=1, then → IDLE. A held-low line therefore yields exactly one frame, with `frame_err`=1 and data = 0.
- Commit rule at frame completion:
  - If the holding register is empty, or is being emptied this cycle (`rx_valid & rx_ready`): load data and both flags; `rx_valid`=1 next cycle.
  - Otherwise: discard the new frame, keep the held word, pulse `overrun` for one cycle.
- Handshake:
  - `rx_valid` stays high until a cycle with `rx_ready`=1, then clears the following cycle unless a simultaneous commit reloads it.
  - Held data and flags never change while `rx_valid`=1 and `rx_ready`=0.
- Reset (any state, mid-frame included) forces:
  - FSM → IDLE; counters = 0.
  - `rx_data` = 0; `rx_valid`, `parity_err`, `frame_err`, `overrun` = 0.
  - Synchroniser flops = 1.
  - The partial frame is discarded.

## Timing
- Sample point: counter = C-1 in each bit period, i.e. one bit period after the verified start midpoint.
- Latency: `rx_valid` rises exactly 3 + H + (DATA_BITS + P + STOP_BITS)·C cycles after the `rxd` falling edge, where P = (PARITY≠0).
  - Derivation: 2 cycles synchroniser, 1 cycle IDLE detect, H cycles START, then the frame bit periods; the final stop sample then registers into the holding register, so `rx_valid` is high on the following cycle.
- `overrun` is asserted in the same cycle in which a commit would have made `rx_valid` rise.
- `rx_ready` is combinationally used only for the commit decision; no combinational path from any input to any output.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit value (data, parity, stop, and the START check at H) is the 2-of-3 majority of `rxs` at counter values t-2, t-1 and t, where t is the nominal sample point.
  - A single-cycle glitch at the sample point is rejected.
  - Latency is unchanged.
- Undefined: single sample of `rxs` at the nominal sample point; no extra registers.

## Test plan
- 8N1, C=16, `rx_ready`=1, byte 0xA5 → one `rx_valid` pulse, `rx_data`=0xA5, both error flags 0, latency 3+7+160 = 170 cycles from the falling edge.
- 7E2, C=16, byte 0x41 with a correct even-parity bit → `parity_err`=0. Repeat with the parity bit flipped → `parity_err`=1; the data is still delivered as 0x41.
- 8N1, C=16, `rxd` held low for 30 bit times → exactly one word: 0x00, `frame_err`=1. No further word until `rxd` returns high and a new start bit arrives.
- `rx_ready`=0, two back-to-back frames 0x11 then 0x22 → `rx_data` holds 0x11 and `overrun` pulses once at the second frame's completion. Raising `rx_ready` afterwards → `rx_valid` drops; 0x22 is never presented.
- 2-cycle low glitch on idle `rxd` (C=16) → no output. With `UART_RX_MAJORITY_EN`, a 1-cycle high glitch centred on a data-bit sample point → the bit is still received correctly.
- `rst` asserted mid-DATA of frame 0x5A → all outputs 0 the next cycle; a subsequent clean frame 0x3C is received correctly.
